bilbo_reg: RTL and testbench
============================

Name: bilbo_reg

Overview:
Parametrised multi-mode BILBO register, the successor to the discrete bilbo_dff chain. One WIDTH-bit register is selected by b1/b2 into one of four modes: normal capture, serial scan, PRPG/MISR test, or clear. It adds an internal LFSR feedback network, all-zero lock-up recovery, and a signature-length counter with a done flag. It sits at combinational-block boundaries in the datapath and is chained serially through tdi/tdo.

Parameters:
WIDTH, 8, register width in bits (>=2)
TAPS, 8'b1000_1110, feedback tap mask; fb = XOR of (q & TAPS)
SEED, 8'b0000_0001, nonzero state loaded on PRPG zero lock-up
SIG_CYCLES, 16, number of MISR compression cycles before sig_done (>=1)
CNT_W, 8, counter width; must satisfy 2^CNT_W > SIG_CYCLES

Ports:
clk  in  1  system clock; all state updates on rising edge
rst  in  1  synchronous, active-high reset
b1  in  1  mode select bit 1
b2  in  1  mode select bit 0
prpg  in  1  in test mode: 1 = pure pattern generation, 0 = MISR compression
tdi  in  1  serial scan input into q[WIDTH-1]
par_in  in  WIDTH  parallel data / signature input
q  out  WIDTH  register contents, driven directly from flops
tdo  out  1  serial scan output, = q[0]
sig_done  out  1  registered; high once SIG_CYCLES MISR updates have completed

Behaviour:
- Reset: rst=1 at a clock edge -> q=0, cnt=0, sig_done=0. rst has priority over every mode, including mid-run.
- fb = ^(q & TAPS), computed from current q.
- Mode {b1,b2}=11, normal: q <= par_in. cnt and sig_done cleared.
- Mode 00, scan: q[WIDTH-1] <= tdi; q[i] <= q[i+1] for i < WIDTH-1. Shift direction is MSB toward LSB. cnt and sig_done cleared.
- Mode 01, clear: q <= 0. cnt and sig_done cleared.
- Mode 10 with prpg=1, PRPG:
  - q[WIDTH-1] <= fb; q[i] <= q[i+1]; par_in is ignored.
  - If q==0 at the edge, q <= SEED instead (lock-up recovery).
  - cnt and sig_done are held at 0.
- Mode 10 with prpg=0, MISR:
  - While sig_done=0: q[WIDTH-1] <= fb ^ par_in[WIDTH-1]; q[i] <= q[i+1] ^ par_in[i]; cnt <= cnt+1.
  - An all-zero q is legal here; no seed load.
  - The edge on which cnt == SIG_CYCLES-1 performs the final update and sets sig_done=1.
  - While sig_done=1: q and cnt hold (signature frozen), regardless of par_in.
- Leaving MISR mode by any mode change or a prpg toggle clears cnt and sig_done on that edge. Re-entering starts a fresh count from the current q, so no re-seed is needed.
- Mode or prpg changes take effect on the next edge; no internal pipelining. Latency is 1 clock in every mode.
- tdo is combinational from q[0], so there is no extra stage in the chain.

Test Plan:
- Scan (WIDTH=4): rst, then b1b2=00, tdi=1 for 4 clocks -> q = 1000, 1100, 1110, 1111; tdo=1 only after the 4th edge. Then tdi=0 for 4 clocks -> q returns to 0000.
- Normal/clear: b1b2=11, par_in=4'hA -> q=A after 1 edge. Then b1b2=01 -> q=0 after 1 edge. rst asserted during 11 with par_in=F -> q=0.
- PRPG (WIDTH=4, TAPS=0011, SEED=0001): from q=0 with b1b2=10, prpg=1 -> q = 0001 (seed), 1000, 0100, 0010, 1001. Run 15 more clocks -> q back to 1001, proving period 15.
- MISR (same params): q=0, prpg=0, par_in=0101 for 1 edge -> q=0101. Then par_in=0000 -> q=1010.
- sig_done (SIG_CYCLES=3): 3 MISR edges -> sig_done=1 on the 3rd edge. Toggle par_in for 5 more clocks -> q unchanged. Switch to 11 -> sig_done=0 on that edge.
- rst mid-MISR at cnt=1 -> q=0, cnt=0, sig_done=0. Resuming MISR then needs a full 3 cycles to reach sig_done.

Source files
------------

// File: rtl/bilbo_reg.sv
// Multi-mode BILBO register: parallel capture, serial scan, PRPG/MISR self-test and clear,
// with all-zero lock-up recovery in PRPG and a signature-length counter in MISR.
module bilbo_reg #(
  parameter int               WIDTH      = 8,
  parameter logic [WIDTH-1:0] TAPS       = 8'b1000_1110,
  parameter logic [WIDTH-1:0] SEED       = 8'b0000_0001,
  parameter int               SIG_CYCLES = 16,
  parameter int               CNT_W      = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             b1,
  input  logic             b2,
  input  logic             prpg,
  input  logic             tdi,
  input  logic [WIDTH-1:0] par_in,
  output logic [WIDTH-1:0] q,
  output logic             tdo,
  output logic             sig_done
);

  typedef enum logic [1:0] {
    MODE_SCAN   = 2'b00,
    MODE_CLEAR  = 2'b01,
    MODE_TEST   = 2'b10,
    MODE_NORMAL = 2'b11
  } mode_t;

  mode_t            mode;
  logic [WIDTH-1:0] q_next;
  logic [WIDTH-1:0] shifted;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  logic             done_next;

  function automatic logic feedback(input logic [WIDTH-1:0] state);
    return ^(state & TAPS);
  endfunction

  assign mode    = mode_t'({b1, b2});
  assign shifted = {feedback(q), q[WIDTH-1:1]};
  assign tdo     = q[0];

  // Counter and done flag default to cleared so that any exit from MISR restarts the count.
  always_comb begin
    q_next    = q;
    cnt_next  = '0;
    done_next = 1'b0;
    unique case (mode)
      MODE_NORMAL: q_next = par_in;
      MODE_SCAN:   q_next = {tdi, q[WIDTH-1:1]};
      MODE_CLEAR:  q_next = '0;
      MODE_TEST: begin
        if (prpg) begin
          q_next = (q == '0) ? SEED : shifted;
        end else if (sig_done) begin
          cnt_next  = cnt;
          done_next = 1'b1;
        end else begin
          q_next    = shifted ^ par_in;
          cnt_next  = cnt + 1'b1;
          done_next = (cnt == CNT_W'(SIG_CYCLES - 1));
        end
      end
      default: q_next = q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q        <= '0;
      cnt      <= '0;
      sig_done <= 1'b0;
    end else begin
      q        <= q_next;
      cnt      <= cnt_next;
      sig_done <= done_next;
    end
  end

endmodule

// File: tb/tb_bilbo_reg.sv
// Bench for bilbo_reg at WIDTH=4, TAPS=0011, SEED=0001, SIG_CYCLES=3: vector table
// followed by hand-written signature-freeze and prpg-toggle sequences.
module tb_bilbo_reg;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       b1 = 1'b0;
  logic       b2 = 1'b0;
  logic       prpg = 1'b0;
  logic       tdi = 1'b0;
  logic [3:0] par_in = 4'h0;
  logic [3:0] q;
  logic       tdo;
  logic       sig_done;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    string      name;
    logic       rst;
    logic       b1;
    logic       b2;
    logic       prpg;
    logic       tdi;
    logic [3:0] par_in;
    logic [3:0] exp_q;
    logic       exp_tdo;
    logic       exp_done;
  } vec_t;

  vec_t vecs[$];

  bilbo_reg #(
    .WIDTH(4),
    .TAPS(4'b0011),
    .SEED(4'b0001),
    .SIG_CYCLES(3),
    .CNT_W(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .b1(b1),
    .b2(b2),
    .prpg(prpg),
    .tdi(tdi),
    .par_in(par_in),
    .q(q),
    .tdo(tdo),
    .sig_done(sig_done)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(string n, logic r, logic m1, logic m2, logic p, logic t,
                              logic [3:0] pin, logic [3:0] eq, logic et, logic ed);
    vec_t v;
    v.name = n; v.rst = r; v.b1 = m1; v.b2 = m2; v.prpg = p; v.tdi = t;
    v.par_in = pin; v.exp_q = eq; v.exp_tdo = et; v.exp_done = ed;
    return v;
  endfunction

  task automatic drive(input logic r, input logic m1, input logic m2, input logic p,
                       input logic t, input logic [3:0] pin);
    rst = r; b1 = m1; b2 = m2; prpg = p; tdi = t; par_in = pin;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string n, input logic [3:0] eq, input logic et, input logic ed);
    n_tests++;
    if (q !== eq) begin
      n_fail++;
      $display("FAIL %s q: got %b, expected %b", n, q, eq);
    end
    n_tests++;
    if (tdo !== et) begin
      n_fail++;
      $display("FAIL %s tdo: got %b, expected %b", n, tdo, et);
    end
    n_tests++;
    if (sig_done !== ed) begin
      n_fail++;
      $display("FAIL %s sig_done: got %b, expected %b", n, sig_done, ed);
    end
  endtask

  initial begin
    //                 name           rst b1 b2 prpg tdi par      q     tdo done
    vecs.push_back(mk("reset",        1, 0, 0, 0, 0, 4'b0000, 4'b0000, 0, 0));
    vecs.push_back(mk("scan1_a",      0, 0, 0, 0, 1, 4'b0000, 4'b1000, 0, 0));
    vecs.push_back(mk("scan1_b",      0, 0, 0, 0, 1, 4'b0000, 4'b1100, 0, 0));
    vecs.push_back(mk("scan1_c",      0, 0, 0, 0, 1, 4'b0000, 4'b1110, 0, 0));
    vecs.push_back(mk("scan1_d",      0, 0, 0, 0, 1, 4'b0000, 4'b1111, 1, 0));
    vecs.push_back(mk("scan0_a",      0, 0, 0, 0, 0, 4'b1111, 4'b0111, 1, 0));
    vecs.push_back(mk("scan0_b",      0, 0, 0, 0, 0, 4'b1111, 4'b0011, 1, 0));
    vecs.push_back(mk("scan0_c",      0, 0, 0, 0, 0, 4'b1111, 4'b0001, 1, 0));
    vecs.push_back(mk("scan0_d",      0, 0, 0, 0, 0, 4'b1111, 4'b0000, 0, 0));
    vecs.push_back(mk("normal_A",     0, 1, 1, 0, 1, 4'b1010, 4'b1010, 0, 0));
    vecs.push_back(mk("clear",        0, 0, 1, 0, 1, 4'b1111, 4'b0000, 0, 0));
    vecs.push_back(mk("normal_F",     0, 1, 1, 0, 0, 4'b1111, 4'b1111, 1, 0));
    vecs.push_back(mk("rst_normal",   1, 1, 1, 0, 0, 4'b1111, 4'b0000, 0, 0));
    vecs.push_back(mk("prpg_seed",    0, 1, 0, 1, 0, 4'b1111, 4'b0001, 1, 0));
    vecs.push_back(mk("prpg_1",       0, 1, 0, 1, 0, 4'b0110, 4'b1000, 0, 0));
    vecs.push_back(mk("prpg_2",       0, 1, 0, 1, 0, 4'b1111, 4'b0100, 0, 0));
    vecs.push_back(mk("prpg_3",       0, 1, 0, 1, 0, 4'b0000, 4'b0010, 0, 0));
    vecs.push_back(mk("prpg_4",       0, 1, 0, 1, 0, 4'b0000, 4'b1001, 1, 0));
    // One full period of x^4+x+1 starting from 1001.
    vecs.push_back(mk("per_01",       0, 1, 0, 1, 0, 4'b0000, 4'b1100, 0, 0));
    vecs.push_back(mk("per_02",       0, 1, 0, 1, 0, 4'b0000, 4'b0110, 0, 0));
    vecs.push_back(mk("per_03",       0, 1, 0, 1, 0, 4'b0000, 4'b1011, 1, 0));
    vecs.push_back(mk("per_04",       0, 1, 0, 1, 0, 4'b0000, 4'b0101, 1, 0));
    vecs.push_back(mk("per_05",       0, 1, 0, 1, 0, 4'b0000, 4'b1010, 0, 0));
    vecs.push_back(mk("per_06",       0, 1, 0, 1, 0, 4'b0000, 4'b1101, 1, 0));
    vecs.push_back(mk("per_07",       0, 1, 0, 1, 0, 4'b0000, 4'b1110, 0, 0));
    vecs.push_back(mk("per_08",       0, 1, 0, 1, 0, 4'b0000, 4'b1111, 1, 0));
    vecs.push_back(mk("per_09",       0, 1, 0, 1, 0, 4'b0000, 4'b0111, 1, 0));
    vecs.push_back(mk("per_10",       0, 1, 0, 1, 0, 4'b0000, 4'b0011, 1, 0));
    vecs.push_back(mk("per_11",       0, 1, 0, 1, 0, 4'b0000, 4'b0001, 1, 0));
    vecs.push_back(mk("per_12",       0, 1, 0, 1, 0, 4'b0000, 4'b1000, 0, 0));
    vecs.push_back(mk("per_13",       0, 1, 0, 1, 0, 4'b0000, 4'b0100, 0, 0));
    vecs.push_back(mk("per_14",       0, 1, 0, 1, 0, 4'b0000, 4'b0010, 0, 0));
    vecs.push_back(mk("per_15",       0, 1, 0, 1, 0, 4'b0000, 4'b1001, 1, 0));
    vecs.push_back(mk("misr_clr",     0, 0, 1, 0, 0, 4'b0000, 4'b0000, 0, 0));
    vecs.push_back(mk("misr_1",       0, 1, 0, 0, 0, 4'b0101, 4'b0101, 1, 0));
    vecs.push_back(mk("misr_2",       0, 1, 0, 0, 0, 4'b0000, 4'b1010, 0, 0));
    vecs.push_back(mk("misr_3_done",  0, 1, 0, 0, 0, 4'b0000, 4'b1101, 1, 1));
    vecs.push_back(mk("exit_normal",  0, 1, 1, 0, 0, 4'b0011, 4'b0011, 1, 0));
    vecs.push_back(mk("mid_clr",      0, 0, 1, 0, 0, 4'b0000, 4'b0000, 0, 0));
    vecs.push_back(mk("mid_misr1",    0, 1, 0, 0, 0, 4'b0000, 4'b0000, 0, 0));
    vecs.push_back(mk("mid_rst",      1, 1, 0, 0, 0, 4'b0110, 4'b0000, 0, 0));
    vecs.push_back(mk("resume_1",     0, 1, 0, 0, 0, 4'b0000, 4'b0000, 0, 0));
    vecs.push_back(mk("resume_2",     0, 1, 0, 0, 0, 4'b0000, 4'b0000, 0, 0));
    vecs.push_back(mk("resume_3",     0, 1, 0, 0, 0, 4'b0000, 4'b0000, 0, 1));

    repeat (2) @(posedge clk);
    #1;
    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].b1, vecs[i].b2, vecs[i].prpg, vecs[i].tdi, vecs[i].par_in);
      check(vecs[i].name, vecs[i].exp_q, vecs[i].exp_tdo, vecs[i].exp_done);
    end

    // Frozen signature ignores par_in; a prpg toggle releases it and restarts the count.
    drive(1, 0, 0, 0, 0, 4'b0000);
    drive(0, 0, 1, 0, 0, 4'b0000);
    drive(0, 1, 0, 0, 0, 4'b0101);
    drive(0, 1, 0, 0, 0, 4'b0000);
    drive(0, 1, 0, 0, 0, 4'b0000);
    check("freeze_start", 4'b1101, 1, 1);
    for (int k = 0; k < 5; k++) begin
      drive(0, 1, 0, 0, 0, (k % 2 == 0) ? 4'b1111 : 4'b0110);
      check($sformatf("frozen_%0d", k), 4'b1101, 1, 1);
    end
    drive(0, 1, 0, 1, 0, 4'b1111);
    check("prpg_toggle", 4'b1110, 0, 0);
    drive(0, 1, 0, 0, 0, 4'b0000);
    check("remisr_1", 4'b1111, 1, 0);
    drive(0, 1, 0, 0, 0, 4'b0000);
    check("remisr_2", 4'b0111, 1, 0);
    drive(0, 1, 0, 0, 0, 4'b0000);
    check("remisr_3", 4'b0011, 1, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
